// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if
//   Handshake and operand/result bundle for the bit-serial adder.
//
//   Signals:
//     start     request to add op_a + op_b (driven by the requester)
//     op_a      operand A, WIDTH bits
//     op_b      operand B, WIDTH bits
//     busy      addition in progress
//     done      one-cycle pulse, sum/carry_out just updated
//     sum       low WIDTH bits of the result
//     carry_out result bit WIDTH
//
//   Modports:
//     master  requester side (drives start/operands, observes results)
//     slave   adder side (observes start/operands, drives results)
// ---------------------------------------------------------------------------
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
        output start,
        output op_a,
        output op_b,
        input  busy,
        input  done,
        input  sum,
        input  carry_out
    );

    modport slave (
        input  start,
        input  op_a,
        input  op_b,
        output busy,
        output done,
        output sum,
        output carry_out
    );

endinterface

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   One-bit half adder, the combinational building block of the serial
//   adder's full-adder cell.
//
//   Ports:
//     a, b   input bits
//     s      a ^ b
//     c      a & b
// ---------------------------------------------------------------------------
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// ---------------------------------------------------------------------------
// serial_adder
//   Bit-serial unsigned adder. Operands are captured when start is accepted
//   in IDLE, then one bit pair per clock (LSB first) is added together with a
//   registered carry. After WIDTH steps the completed sum and final carry are
//   published on registered outputs and done pulses for one cycle.
//   Throughput is one addition per WIDTH+2 clocks.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | one bit pair added per clock; busy high
//   DONE  | sum/carry_out freshly updated; done high for this single cycle
//
//   Ports:
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     serial_adder_if slave modport:
//               start, op_a, op_b in; busy, done, sum, carry_out out
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] sum_q;
    logic             carry_out_q;
    logic             busy_q;
    logic             done_q;

    logic             load;
    logic             step;
    logic             last;

    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_c;
    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] sr_nxt;

    // -----------------------------------------------------------------------
    // Full adder cell from two half adders
    // -----------------------------------------------------------------------
    half_adder u_ha0 (
        .a (sa[0]),
        .b (sb[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .a (ha0_s),
        .b (carry),
        .s (bit_sum),
        .c (ha1_c)
    );

    assign bit_carry = ha0_c | ha1_c;

    // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at LSB.
    assign sr_nxt = (sr >> 1) | {bit_sum, {(WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: operand shifters, carry flop, bit counter, result shifter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sr    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            sa    <= bus.op_a;
            sb    <= bus.op_b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (step) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            sr    <= sr_nxt;
            carry <= bit_carry;
            cnt   <= cnt + CW'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Registered outputs. busy/done follow the next state so they line up
    // with the state register without any combinational output path.
    // sum/carry_out only change on the final RUN edge and otherwise hold.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            carry_out_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            busy_q <= (state_nxt == S_RUN);
            done_q <= (state_nxt == S_DONE);
            if (last) begin
                sum_q       <= sr_nxt;
                carry_out_q <= bit_carry;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder: an 8-bit instance for the functional,
//   handshake, reset and random scenarios and a 2-bit instance for the
//   exhaustive back-to-back scenario.
// ---------------------------------------------------------------------------
module tb_serial_adder;

    logic clk;
    logic rst_n;

    int checks;
    int errors;
    int done8_seen;

    serial_adder_if #(.WIDTH(8)) ifa ();
    serial_adder_if #(.WIDTH(2)) ifb ();

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ifa.done === 1'b1) done8_seen++;
    end

    // Stimulus driver for one 8-bit addition, starting from IDLE. Returns
    // the observed result, latency (samples after the accepting edge until
    // done, -1 on timeout), busy sample count, the outputs seen just before
    // done, and done one cycle after the pulse.
    task automatic do_add8(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] s, output logic c,
                           output int lat, output int busy_n,
                           output logic [7:0] pre_s, output logic pre_c,
                           output logic done_after);
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.op_a  = a;
        ifa.op_b  = b;
        @(posedge clk);
        #1;
        ifa.start  = 1'b0;
        lat        = -1;
        busy_n     = 0;
        s          = '0;
        c          = 1'b0;
        pre_s      = ifa.sum;
        pre_c      = ifa.carry_out;
        done_after = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (ifa.done === 1'b1) begin
                lat = k;
                s   = ifa.sum;
                c   = ifa.carry_out;
                break;
            end
            if (ifa.busy === 1'b1) busy_n++;
            pre_s = ifa.sum;
            pre_c = ifa.carry_out;
            @(posedge clk);
            #1;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
            done_after = ifa.done;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({ifa.busy, ifa.done, ifa.sum, ifa.carry_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_during8: got %b required 0",
                     {ifa.busy, ifa.done, ifa.sum, ifa.carry_out});
        end
        checks++;
        if ({ifb.busy, ifb.done, ifb.sum, ifb.carry_out} !== 5'd0) begin
            errors++;
            $display("FAIL reset_during2: got %b required 0",
                     {ifb.busy, ifb.done, ifb.sum, ifb.carry_out});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({ifa.busy, ifa.done, ifa.sum, ifa.carry_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_after: got %b required 0",
                     {ifa.busy, ifa.done, ifa.sum, ifa.carry_out});
        end
    endtask

    task automatic test_basic;
        logic [7:0] s, ps;
        logic       c, pc, da;
        int         lat, bn;
        do_add8(8'h0F, 8'h01, s, c, lat, bn, ps, pc, da);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: got %0d required 8", lat);
        end
        checks++;
        if (bn !== 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d required 8", bn);
        end
        checks++;
        if ({c, s} !== 9'h010) begin
            errors++;
            $display("FAIL basic_result: got %h required 010", {c, s});
        end
        checks++;
        if (da !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_width: done after pulse %b required 0", da);
        end
    endtask

    task automatic test_carry_and_hold;
        logic [7:0] s, ps;
        logic       c, pc, da;
        int         lat, bn;
        do_add8(8'hFF, 8'h01, s, c, lat, bn, ps, pc, da);
        checks++;
        if ({c, s} !== 9'h100 || lat !== 8) begin
            errors++;
            $display("FAIL ff_plus_01: got %h lat %0d required 100 lat 8", {c, s}, lat);
        end
        do_add8(8'hFF, 8'hFF, s, c, lat, bn, ps, pc, da);
        checks++;
        if ({c, s} !== 9'h1FE || lat !== 8) begin
            errors++;
            $display("FAIL ff_plus_ff: got %h lat %0d required 1fe lat 8", {c, s}, lat);
        end
        do_add8(8'h00, 8'h00, s, c, lat, bn, ps, pc, da);
        checks++;
        if ({pc, ps} !== 9'h1FE) begin
            errors++;
            $display("FAIL hold_prev: got %h required 1fe", {pc, ps});
        end
        checks++;
        if ({c, s} !== 9'h000 || lat !== 8) begin
            errors++;
            $display("FAIL zero_plus_zero: got %h lat %0d required 000 lat 8", {c, s}, lat);
        end
    endtask

    task automatic test_start_ignored;
        int done_n, first_k, second_k;
        logic [8:0] r1, r2;
        logic b9, b10;
        done_n   = 0;
        first_k  = -1;
        second_k = -1;
        r1 = '0;
        r2 = '0;
        b9 = 1'b1;
        b10 = 1'b0;
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.op_a  = 8'h55;
        ifa.op_b  = 8'hAA;
        @(posedge clk);
        #1;
        ifa.op_a = 8'h01;
        ifa.op_b = 8'h01;
        for (int k = 0; k < 20; k++) begin
            if (ifa.done === 1'b1) begin
                done_n++;
                if (done_n == 1) begin
                    first_k = k;
                    r1 = {ifa.carry_out, ifa.sum};
                end else begin
                    second_k = k;
                    r2 = {ifa.carry_out, ifa.sum};
                end
            end
            if (k == 9) b9 = ifa.busy;
            if (k == 10) begin
                b10 = ifa.busy;
                ifa.start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (r1 !== 9'h0FF || first_k !== 8) begin
            errors++;
            $display("FAIL held_start_first: got %h at %0d required 0ff at 8", r1, first_k);
        end
        checks++;
        if (b9 !== 1'b0 || b10 !== 1'b1) begin
            errors++;
            $display("FAIL held_start_reaccept: busy E9 %b E10 %b required 0 1", b9, b10);
        end
        checks++;
        if (r2 !== 9'h002 || second_k !== 18) begin
            errors++;
            $display("FAIL held_start_second: got %h at %0d required 002 at 18", r2, second_k);
        end
        checks++;
        if (done_n !== 2) begin
            errors++;
            $display("FAIL held_start_pulses: got %0d required 2", done_n);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [7:0] s, ps;
        logic       c, pc, da;
        int         lat, bn, dn;
        @(negedge clk);
        ifa.start = 1'b1;
        ifa.op_a  = 8'h80;
        ifa.op_b  = 8'h80;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.busy, ifa.done, ifa.sum, ifa.carry_out} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0",
                     {ifa.busy, ifa.done, ifa.sum, ifa.carry_out});
        end
        dn = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (ifa.done !== 1'b0) dn++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (ifa.done !== 1'b0 || ifa.busy !== 1'b0) dn++;
        end
        checks++;
        if (dn !== 0) begin
            errors++;
            $display("FAIL reset_abort_idle: got %0d busy/done samples required 0", dn);
        end
        do_add8(8'h80, 8'h80, s, c, lat, bn, ps, pc, da);
        checks++;
        if ({c, s} !== 9'h100 || lat !== 8) begin
            errors++;
            $display("FAIL after_reset_add: got %h lat %0d required 100 lat 8", {c, s}, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0] pa [16];
        logic [1:0] pb [16];
        logic [2:0] exp_r;
        logic [3:0] idx;
        int p;
        int bad_pulse, bad_val;
        for (int i = 0; i < 16; i++) begin
            idx   = 4'(i);
            pa[i] = idx[3:2];
            pb[i] = idx[1:0];
        end
        bad_pulse = 0;
        bad_val   = 0;
        @(negedge clk);
        ifb.start = 1'b1;
        ifb.op_a  = pa[0];
        ifb.op_b  = pb[0];
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) begin
            if (k % 4 == 0) begin
                p = k / 4;
                if (p < 15) begin
                    ifb.op_a = pa[p+1];
                    ifb.op_b = pb[p+1];
                end else begin
                    ifb.start = 1'b0;
                end
            end
            if (ifb.done !== (k % 4 == 2)) begin
                bad_pulse++;
                $display("FAIL b2b_pulse: sample %0d done %b required %b",
                         k, ifb.done, (k % 4 == 2));
            end
            if (k % 4 == 2) begin
                p     = (k - 2) / 4;
                exp_r = {1'b0, pa[p]} + {1'b0, pb[p]};
                if ({ifb.carry_out, ifb.sum} !== exp_r) begin
                    bad_val++;
                    $display("FAIL b2b_sum: pair %0d got %b required %b",
                             p, {ifb.carry_out, ifb.sum}, exp_r);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad_pulse != 0) errors++;
        checks++;
        if (bad_val != 0) errors++;
    endtask

    task automatic test_random;
        logic [7:0] a, b, s, ps;
        logic       c, pc, da;
        logic [8:0] exp_r;
        int         lat, bn, base, bad;
        base = done8_seen;
        bad  = 0;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a = 8'($urandom);
            b = 8'($urandom);
            exp_r = {1'b0, a} + {1'b0, b};
            do_add8(a, b, s, c, lat, bn, ps, pc, da);
            if ({c, s} !== exp_r || lat !== 8) begin
                bad++;
                $display("FAIL random_add: %h+%h got %h lat %0d required %h lat 8",
                         a, b, {c, s}, lat, exp_r);
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (done8_seen - base !== 1000) begin
            errors++;
            $display("FAIL random_done_count: got %0d required 1000", done8_seen - base);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        done8_seen = 0;
        rst_n      = 1'b0;
        ifa.start  = 1'b0;
        ifa.op_a   = '0;
        ifa.op_b   = '0;
        ifb.start  = 1'b0;
        ifb.op_a   = '0;
        ifb.op_b   = '0;

        test_reset();
        test_basic();
        test_carry_and_hold();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
